// File: rtl/id_stage_pipe_pkg.sv
//----------------------------------------------------------------------------
// Module : id_pkg
// Brief  : Field positions, op classes, ALU codes and control decode for ID.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

package id_pkg;

  localparam int OP_LSB = 26;
  localparam int RD_LSB = 21;
  localparam int RA_LSB = 16;
  localparam int RB_LSB = 11;
  localparam int IMM_W  = 16;

  localparam logic [1:0] CLS_RR  = 2'b00;
  localparam logic [1:0] CLS_RI  = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;
  localparam logic [1:0] CLS_BR  = 2'b11;

  localparam logic [4:0] ALU_ADD = 5'h00;
  localparam logic [4:0] ALU_SUB = 5'h10;

  typedef struct packed {
    logic [4:0] op_alu;
    logic       w_rf;
    logic       w_dm;
    logic       s_mxse;
    logic       branch;
  } ctrl_t;

  function automatic ctrl_t decode_op(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op[5:4])
      CLS_RR: begin
        c.op_alu = {1'b0, op[3:0]};
        c.w_rf   = 1'b1;
      end
      CLS_RI: begin
        c.op_alu = {1'b0, op[3:0]};
        c.w_rf   = 1'b1;
        c.s_mxse = 1'b1;
      end
      CLS_MEM: begin
        c.op_alu = ALU_ADD;
        c.s_mxse = 1'b1;
        c.w_dm   = op[0];
        c.w_rf   = ~op[0];
      end
      default: begin
        c.op_alu = ALU_SUB;
        c.branch = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_pipe_if.sv
//----------------------------------------------------------------------------
// Module : id_stage_pipe_if
// Brief  : IF-side, EX-side and write-back signals of the ID stage.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

interface id_stage_pipe_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [XLEN-1:0]   in_pc;
  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pra;
  logic [XLEN-1:0]   out_prb;
  logic [XLEN-1:0]   out_imm;
  logic [REG_AW-1:0] out_rd;
  logic [XLEN-1:0]   out_pc;
  logic [4:0]        out_op_alu;
  logic              out_w_rf;
  logic              out_w_dm;
  logic              out_s_mxse;
  logic              out_branch;

  modport master (
    output in_valid, in_instr, in_pc, wb_we, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_pra, out_prb, out_imm, out_rd, out_pc,
           out_op_alu, out_w_rf, out_w_dm, out_s_mxse, out_branch
  );

  modport slave (
    input  in_valid, in_instr, in_pc, wb_we, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_pra, out_prb, out_imm, out_rd, out_pc,
           out_op_alu, out_w_rf, out_w_dm, out_s_mxse, out_branch
  );
endinterface

`default_nettype wire

// File: rtl/id_stage_pipe_regfile.sv
//----------------------------------------------------------------------------
// Module : id_regfile
// Brief  : NREGS x XLEN register file, 2 async reads, 1 sync write.
//          ID_WB_BYPASS_EN: same-cycle write-back is visible on reads.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module id_regfile
  import id_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 16,
  parameter int ZERO_R0 = 1,
  parameter int REG_AW  = $clog2(NREGS)
) (
  input  wire logic              CLK,
  input  wire logic              RESET,
  input  wire logic [REG_AW-1:0] ra_addr_i,
  input  wire logic [REG_AW-1:0] rb_addr_i,
  output logic      [XLEN-1:0]   ra_data_o,
  output logic      [XLEN-1:0]   rb_data_o,
  input  wire logic              wb_we_i,
  input  wire logic [REG_AW-1:0] wb_addr_i,
  input  wire logic [XLEN-1:0]   wb_data_i
);

  logic [XLEN-1:0]   regs_q [NREGS];
  logic [REG_AW-1:0] raddr  [2];
  logic [XLEN-1:0]   rdata  [2];
  logic              wr_en;

  assign wr_en = wb_we_i && !((ZERO_R0 != 0) && (wb_addr_i == '0));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  assign raddr[0]  = ra_addr_i;
  assign raddr[1]  = rb_addr_i;
  assign ra_data_o = rdata[0];
  assign rb_data_o = rdata[1];

  for (genvar p = 0; p < 2; p++) begin : g_rport
    always_comb begin
      rdata[p] = regs_q[raddr[p]];
`ifdef ID_WB_BYPASS_EN
      if (wb_we_i && (wb_addr_i == raddr[p])) rdata[p] = wb_data_i;
`endif
      // r0 hard-wired zero wins over any bypass
      if ((ZERO_R0 != 0) && (raddr[p] == '0)) rdata[p] = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_stage_pipe.sv
//----------------------------------------------------------------------------
// Module : id_stage_pipe
// Brief  : Registered instruction-decode stage with valid/ready on both sides.
//          Optional ID_WB_BYPASS_EN enables write-first register reads.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 16,
  parameter int ZERO_R0 = 1
) (
  input wire logic     CLK,
  input wire logic     RESET,
  input wire logic     FLUSH,
  id_stage_pipe_if.slave bus
);

  localparam int REG_AW = $clog2(NREGS);

  logic [REG_AW-1:0] ra_idx, rb_idx, rd_idx;
  logic [XLEN-1:0]   ra_val, rb_val, imm_d;
  ctrl_t             ctrl_d;
  logic              accept, hold, unused_instr;
  logic              refresh_a, refresh_b;

  logic              valid_q;
  logic [XLEN-1:0]   pra_q, prb_q, imm_q, pc_q;
  logic [REG_AW-1:0] ra_q, rb_q, rd_q;
  ctrl_t             ctrl_q;

  assign ra_idx       = bus.in_instr[RA_LSB +: REG_AW];
  assign rb_idx       = bus.in_instr[RB_LSB +: REG_AW];
  assign rd_idx       = bus.in_instr[RD_LSB +: REG_AW];
  assign imm_d        = XLEN'($signed(bus.in_instr[IMM_W-1:0]));
  assign ctrl_d       = decode_op(bus.in_instr[31:OP_LSB]);
  assign unused_instr = ^bus.in_instr;

  id_regfile #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .ZERO_R0 (ZERO_R0),
    .REG_AW  (REG_AW)
  ) u_regfile (
    .CLK       (CLK),
    .RESET     (RESET),
    .ra_addr_i (ra_idx),
    .rb_addr_i (rb_idx),
    .ra_data_o (ra_val),
    .rb_data_o (rb_val),
    .wb_we_i   (bus.wb_we),
    .wb_addr_i (bus.wb_addr),
    .wb_data_i (bus.wb_data)
  );

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign hold         = valid_q && !bus.out_ready;

  // A stalled bundle tracks write-backs to its sources so EX sees fresh data
  assign refresh_a = bus.wb_we && (bus.wb_addr == ra_q) && !((ZERO_R0 != 0) && (ra_q == '0));
  assign refresh_b = bus.wb_we && (bus.wb_addr == rb_q) && !((ZERO_R0 != 0) && (rb_q == '0));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= 1'b0;
      pra_q   <= '0;
      prb_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else if (FLUSH) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      pra_q   <= ra_val;
      prb_q   <= rb_val;
      imm_q   <= imm_d;
      pc_q    <= bus.in_pc;
      ra_q    <= ra_idx;
      rb_q    <= rb_idx;
      rd_q    <= rd_idx;
      ctrl_q  <= ctrl_d;
    end else if (hold) begin
      if (refresh_a) pra_q <= bus.wb_data;
      if (refresh_b) prb_q <= bus.wb_data;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_pra    = pra_q;
  assign bus.out_prb    = prb_q;
  assign bus.out_imm    = imm_q;
  assign bus.out_rd     = rd_q;
  assign bus.out_pc     = pc_q;
  assign bus.out_op_alu = ctrl_q.op_alu;
  assign bus.out_w_rf   = ctrl_q.w_rf;
  assign bus.out_w_dm   = ctrl_q.w_dm;
  assign bus.out_s_mxse = ctrl_q.s_mxse;
  assign bus.out_branch = ctrl_q.branch;

endmodule

`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
//----------------------------------------------------------------------------
// Module : tb_id_stage_pipe
// Brief  : Directed plus random stimulus against a cycle-level reference model.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_id_stage_pipe;

  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int AW    = 4;

  logic CLK = 1'b0;
  logic RESET, FLUSH;
  always #5 CLK = ~CLK;

  id_stage_pipe_if #(.XLEN(XLEN), .REG_AW(AW)) bus ();

  id_stage_pipe #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_R0(1)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .FLUSH (FLUSH),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [XLEN-1:0] mrf [NREGS];
  bit              mv;
  logic [XLEN-1:0] m_pra, m_prb, m_imm, m_pc;
  logic [AW-1:0]   m_ra, m_rb, m_rd;
  logic [4:0]      m_alu;
  bit              m_wrf, m_wdm, m_s, m_br;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input int rd, input int ra,
                                     input logic [15:0] imm);
    return {op, 5'(rd), 5'(ra), imm};
  endfunction

  function automatic logic [XLEN-1:0] mread(input int idx);
    if (idx == 0) return '0;
`ifdef ID_WB_BYPASS_EN
    if (bus.wb_we && int'(bus.wb_addr) == idx) return bus.wb_data;
`endif
    return mrf[idx];
  endfunction

  task automatic model_step();
    bit          take;
    logic [5:0]  op;
    logic [15:0] i16;
    take = bus.in_valid && (!mv || bus.out_ready);
    op   = bus.in_instr[31:26];
    i16  = bus.in_instr[15:0];
    if (RESET) begin
      mv = 0; m_pra = 0; m_prb = 0; m_imm = 0; m_pc = 0;
      m_ra = 0; m_rb = 0; m_rd = 0; m_alu = 0;
      m_wrf = 0; m_wdm = 0; m_s = 0; m_br = 0;
      for (int i = 0; i < NREGS; i++) mrf[i] = '0;
    end else begin
      if (FLUSH) mv = 0;
      else if (take) begin
        mv    = 1;
        m_ra  = bus.in_instr[19:16];
        m_rb  = bus.in_instr[14:11];
        m_rd  = bus.in_instr[24:21];
        m_pra = mread(int'(m_ra));
        m_prb = mread(int'(m_rb));
        m_imm = {{16{i16[15]}}, i16};
        m_pc  = bus.in_pc;
        m_wrf = 0; m_wdm = 0; m_s = 0; m_br = 0;
        case (op[5:4])
          2'd0: begin m_alu = {1'b0, op[3:0]}; m_wrf = 1; end
          2'd1: begin m_alu = {1'b0, op[3:0]}; m_wrf = 1; m_s = 1; end
          2'd2: begin m_alu = 5'h00; m_s = 1; if (op[0]) m_wdm = 1; else m_wrf = 1; end
          default: begin m_alu = 5'h10; m_br = 1; end
        endcase
      end else if (mv && !bus.out_ready) begin
        if (bus.wb_we && bus.wb_addr == m_ra && m_ra != 0) m_pra = bus.wb_data;
        if (bus.wb_we && bus.wb_addr == m_rb && m_rb != 0) m_prb = bus.wb_data;
      end else mv = 0;
      if (bus.wb_we && bus.wb_addr != 0) mrf[bus.wb_addr] = bus.wb_data;
    end
  endtask

  // Compare at negedge, advance the model, then step past the next posedge
  task automatic tick();
    @(negedge CLK);
    chk("in_ready", 64'(bus.in_ready), 64'(!mv || bus.out_ready));
    chk("out_valid", 64'(bus.out_valid), 64'(mv));
    if (mv) begin
      chk("pra", 64'(bus.out_pra), 64'(m_pra));
      chk("prb", 64'(bus.out_prb), 64'(m_prb));
      chk("imm", 64'(bus.out_imm), 64'(m_imm));
      chk("rd", 64'(bus.out_rd), 64'(m_rd));
      chk("pc", 64'(bus.out_pc), 64'(m_pc));
      chk("op_alu", 64'(bus.out_op_alu), 64'(m_alu));
      chk("ctrl", 64'({bus.out_w_rf, bus.out_w_dm, bus.out_s_mxse, bus.out_branch}),
          64'({m_wrf, m_wdm, m_s, m_br}));
    end
    model_step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [XLEN-1:0] pc_hold, imm_hold;
    logic [AW-1:0]   rd_hold;
    int              nvalid;

    RESET = 1; FLUSH = 0;
    bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0;
    bus.wb_we = 0; bus.wb_addr = '0; bus.wb_data = '0; bus.out_ready = 1;
    mv = 0;
    @(posedge CLK); #1;
    tick(); tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_fields", 64'(bus.out_pra | bus.out_prb | bus.out_imm | bus.out_pc), 64'd0);
    chk("rst_ctrl", 64'({bus.out_rd, bus.out_op_alu, bus.out_w_rf, bus.out_w_dm,
                        bus.out_s_mxse, bus.out_branch}), 64'd0);
    RESET = 0;

    // Register file cleared by reset
    for (int i = 1; i < 16; i++) begin
      bus.in_valid = 1; bus.in_instr = mk(6'h00, i, i, 16'(i << 11)); bus.in_pc = 32'(i * 4);
      tick();
      chk("rf_clear", 64'(bus.out_pra | bus.out_prb), 64'd0);
    end

    // Write-back then register-immediate decode
    bus.in_valid = 0; bus.wb_we = 1; bus.wb_addr = 3; bus.wb_data = 32'h1234;
    tick();
    bus.wb_we = 0; bus.in_valid = 1; bus.in_instr = mk(6'h11, 2, 3, 16'hFFF0);
    tick();
    chk("ri_op_alu", 64'(bus.out_op_alu), 64'h01);
    chk("ri_pra", 64'(bus.out_pra), 64'h1234);
    chk("ri_imm", 64'(bus.out_imm), 64'hFFFF_FFF0);
    chk("ri_s_mxse_w_rf", 64'({bus.out_s_mxse, bus.out_w_rf}), 64'b11);

    // Stall with write-back refresh of held operand
    bus.in_instr = mk(6'h00, 1, 4, 16'(5 << 11)); bus.in_pc = 32'h100;
    tick();
    pc_hold = bus.out_pc; imm_hold = bus.out_imm; rd_hold = bus.out_rd;
    bus.out_ready = 0; bus.in_instr = mk(6'h01, 9, 9, 16'h0);
    bus.wb_we = 1; bus.wb_addr = 4; bus.wb_data = 32'hAA;
    #1;
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    chk("stall_pra", 64'(bus.out_pra), 64'hAA);
    chk("stall_stable", 64'({bus.out_pc, bus.out_imm[15:0], bus.out_rd}),
        64'({pc_hold, imm_hold[15:0], rd_hold}));
    bus.wb_we = 0; bus.out_ready = 1; bus.in_valid = 0;
    tick();
    chk("consumed", 64'(bus.out_valid), 64'd0);

    // Same-edge write-back and read of r5
    bus.wb_we = 1; bus.wb_addr = 5; bus.wb_data = 32'h11;
    tick();
    bus.in_valid = 1; bus.in_instr = mk(6'h00, 6, 5, 16'h0); bus.wb_data = 32'h55;
    tick();
`ifdef ID_WB_BYPASS_EN
    chk("bypass_pra", 64'(bus.out_pra), 64'h55);
`else
    chk("bypass_pra", 64'(bus.out_pra), 64'h11);
`endif

    // r0 stays zero; flush while stalled keeps the RF write
    bus.in_valid = 0; bus.wb_addr = 0; bus.wb_data = 32'hFFFF;
    tick();
    bus.wb_we = 0; bus.in_valid = 1; bus.in_instr = mk(6'h00, 1, 0, 16'h0);
    tick();
    chk("r0_zero", 64'(bus.out_pra | bus.out_prb), 64'd0);
    bus.in_valid = 0; bus.out_ready = 0; FLUSH = 1;
    bus.wb_we = 1; bus.wb_addr = 7; bus.wb_data = 32'h77;
    tick();
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    FLUSH = 0; bus.wb_we = 0; bus.out_ready = 1;
    bus.in_valid = 1; bus.in_instr = mk(6'h00, 1, 7, 16'h0);
    tick();
    chk("flush_rf_kept", 64'(bus.out_pra), 64'h77);

    // Store and branch decode
    bus.in_instr = mk(6'h21, 3, 1, 16'h0008);
    tick();
    chk("st_ctrl", 64'({bus.out_w_dm, bus.out_w_rf, bus.out_op_alu}), 64'({1'b1, 1'b0, 5'h00}));
    bus.in_instr = mk(6'h30, 0, 1, 16'h0004);
    tick();
    chk("br_ctrl", 64'({bus.out_branch, bus.out_op_alu}), 64'({1'b1, 5'h10}));

    // Back-to-back stream at full rate
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      bus.in_instr = $urandom; bus.in_pc = $urandom;
      tick();
      nvalid += int'(bus.out_valid);
    end
    chk("throughput", 64'(nvalid), 64'd20);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      RESET         = ($urandom_range(0, 63) == 0);
      FLUSH         = ($urandom_range(0, 15) == 0);
      bus.in_valid  = $urandom_range(0, 1) == 1;
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.in_instr  = $urandom;
      bus.in_pc     = $urandom;
      bus.wb_we     = $urandom_range(0, 1) == 1;
      bus.wb_addr   = AW'($urandom_range(0, NREGS - 1));
      bus.wb_data   = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
